// File: rtl/analog_seq_pkg.sv
// ============================================================================
// analog_seq_pkg : shared types and helpers for the analog power sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

package analog_seq_pkg;

    localparam int MAX_CH    = 8;
    localparam int RES_SEL_L = 0;
    localparam int RES_SEL_H = 1;

    typedef enum logic [2:0] {
        ST_OFF         = 3'd0,
        ST_BIAS_SETTLE = 3'd1,
        ST_CH_UP       = 3'd2,
        ST_ON          = 3'd3,
        ST_CH_DOWN     = 3'd4,
        ST_BIAS_DOWN   = 3'd5
    } seq_state_t;

    // One action per clock; the FSM register block only applies what is decided here.
    typedef enum logic [2:0] {
        ACT_NONE     = 3'd0,
        ACT_ACCEPT   = 3'd1,
        ACT_CH_ON    = 3'd2,
        ACT_CH_OFF   = 3'd3,
        ACT_BIAS_OFF = 3'd4,
        ACT_GO_ON    = 3'd5,
        ACT_GO_OFF   = 3'd6,
        ACT_ABORT    = 3'd7
    } seq_act_t;

    function automatic logic [MAX_CH-1:0] lowest_onehot(input logic [MAX_CH-1:0] v);
        return v & (~v + MAX_CH'(1));
    endfunction

    function automatic logic [MAX_CH-1:0] highest_onehot(input logic [MAX_CH-1:0] v);
        logic [MAX_CH-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_CH; i++) begin
            if (v[i]) begin
                r    = '0;
                r[i] = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/settle_timer.sv
// ============================================================================
// settle_timer : loadable down-counter, done pulses LOAD edges after start
// Rev 1.0
// ============================================================================
`default_nettype none

module settle_timer #(
    parameter int TW = 7
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_start,
    input  logic          i_clr,
    input  logic [TW-1:0] i_load,
    output logic          o_done
);

    logic [TW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_start) begin
            r_cnt <= i_load;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - TW'(1);
        end
    end

    // Seen at the edge where the count reaches zero, so a restart there is seamless.
    assign o_done = (r_cnt == TW'(1));

endmodule

`default_nettype wire

// File: rtl/analog_power_sequencer.sv
// ============================================================================
// analog_power_sequencer : timed bias/channel power-up and power-down sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

module analog_power_sequencer
    import analog_seq_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int BIAS_SETTLE = 64,
    parameter int CH_SETTLE   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              req_on,
    input  logic [NUM_CH-1:0] ch_mask,
    input  logic [1:0]        res_sel,
    output logic              en_resl,
    output logic              en_resh,
    output logic [NUM_CH-1:0] ch_en,
    output logic              busy,
    output logic              ready,
    output logic              aborted
);

    localparam int c_MAX_SETTLE = (BIAS_SETTLE > CH_SETTLE) ? BIAS_SETTLE : CH_SETTLE;
    localparam int c_TW         = $clog2(c_MAX_SETTLE + 1);
    localparam logic [c_TW-1:0] c_BIAS_LD = c_TW'(BIAS_SETTLE);
    localparam logic [c_TW-1:0] c_CH_LD   = c_TW'(CH_SETTLE);

    seq_state_t        r_state;
    logic              r_req;
    logic [NUM_CH-1:0] r_mask_in;
    logic [1:0]        r_res_in;
    logic [NUM_CH-1:0] r_mask;
    logic [NUM_CH-1:0] r_ch_en;
    logic              r_en_resl;
    logic              r_en_resh;
    logic              r_busy;
    logic              r_ready;
    logic              r_aborted;

    seq_act_t          w_act;
    seq_act_t          w_down_act;
    logic              w_done;
    logic [NUM_CH-1:0] w_pend;
    logic [NUM_CH-1:0] w_up_bit;
    logic [NUM_CH-1:0] w_dn_bit;
    logic              w_tmr_start;
    logic              w_tmr_clr;
    logic [c_TW-1:0]   w_tmr_load;

    // Channels still waiting to rise; lowest pending goes up next, highest lit goes down next.
    assign w_pend   = r_mask & ~r_ch_en;
    assign w_up_bit = NUM_CH'(lowest_onehot(MAX_CH'(w_pend)));
    assign w_dn_bit = NUM_CH'(highest_onehot(MAX_CH'(r_ch_en)));

    assign w_down_act = (|r_ch_en) ? ACT_CH_OFF : ACT_BIAS_OFF;

    always_comb begin
        w_act = ACT_NONE;
        if (!ena) begin
            if (r_state != ST_OFF) begin
                w_act = ACT_ABORT;
            end
        end else begin
            case (r_state)
                ST_OFF: begin
                    if (r_req && (r_res_in != 2'b00)) begin
                        w_act = ACT_ACCEPT;
                    end
                end
                ST_BIAS_SETTLE, ST_CH_UP: begin
                    if (w_done) begin
                        if (!r_req) begin
                            w_act = w_down_act;
                        end else if (|w_pend) begin
                            w_act = ACT_CH_ON;
                        end else begin
                            w_act = ACT_GO_ON;
                        end
                    end
                end
                ST_ON: begin
                    if (!r_req) begin
                        w_act = w_down_act;
                    end
                end
                ST_CH_DOWN: begin
                    if (w_done) begin
                        w_act = w_down_act;
                    end
                end
                ST_BIAS_DOWN: begin
                    if (w_done) begin
                        w_act = ACT_GO_OFF;
                    end
                end
                default: w_act = ACT_NONE;
            endcase
        end
    end

    assign w_tmr_clr   = (w_act == ACT_ABORT);
    assign w_tmr_start = (w_act == ACT_ACCEPT) || (w_act == ACT_CH_ON) ||
                         (w_act == ACT_CH_OFF) || (w_act == ACT_BIAS_OFF);
    assign w_tmr_load  = ((w_act == ACT_CH_ON) || (w_act == ACT_CH_OFF)) ? c_CH_LD : c_BIAS_LD;

    settle_timer #(
        .TW (c_TW)
    ) u_settle_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (w_tmr_start),
        .i_clr   (w_tmr_clr),
        .i_load  (w_tmr_load),
        .o_done  (w_done)
    );

    // Request inputs pass through one register stage before the FSM acts on them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_OFF;
            r_req     <= 1'b0;
            r_mask_in <= '0;
            r_res_in  <= 2'b00;
            r_mask    <= '0;
            r_ch_en   <= '0;
            r_en_resl <= 1'b0;
            r_en_resh <= 1'b0;
            r_busy    <= 1'b0;
            r_ready   <= 1'b0;
            r_aborted <= 1'b0;
        end else begin
            r_req     <= req_on;
            r_mask_in <= ch_mask;
            r_res_in  <= res_sel;
            r_aborted <= 1'b0;
            case (w_act)
                ACT_ACCEPT: begin
                    r_mask    <= r_mask_in;
                    r_en_resl <= r_res_in[RES_SEL_L];
                    r_en_resh <= r_res_in[RES_SEL_H];
                    r_busy    <= 1'b1;
                    r_state   <= ST_BIAS_SETTLE;
                end
                ACT_CH_ON: begin
                    r_ch_en <= r_ch_en | w_up_bit;
                    r_state <= ST_CH_UP;
                end
                ACT_CH_OFF: begin
                    r_ch_en <= r_ch_en & ~w_dn_bit;
                    r_ready <= 1'b0;
                    r_busy  <= 1'b1;
                    r_state <= ST_CH_DOWN;
                end
                ACT_BIAS_OFF: begin
                    r_en_resl <= 1'b0;
                    r_en_resh <= 1'b0;
                    r_ready   <= 1'b0;
                    r_busy    <= 1'b1;
                    r_state   <= ST_BIAS_DOWN;
                end
                ACT_GO_ON: begin
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_ON;
                end
                ACT_GO_OFF: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_OFF;
                end
                ACT_ABORT: begin
                    r_ch_en   <= '0;
                    r_en_resl <= 1'b0;
                    r_en_resh <= 1'b0;
                    r_busy    <= 1'b0;
                    r_ready   <= 1'b0;
                    r_aborted <= 1'b1;
                    r_state   <= ST_OFF;
                end
                default: begin
                end
            endcase
        end
    end

    assign en_resl = r_en_resl;
    assign en_resh = r_en_resh;
    assign ch_en   = r_ch_en;
    assign busy    = r_busy;
    assign ready   = r_ready;
    assign aborted = r_aborted;

endmodule

`default_nettype wire

// File: tb/tb_analog_power_sequencer.sv
// ============================================================================
// tb_analog_power_sequencer : table, directed and random checks of the sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_analog_power_sequencer;

    localparam int NCH = 4;
    localparam int BS  = 64;
    localparam int CS  = 16;
    localparam int INF = 1 << 30;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           ena;
    logic           req_on;
    logic [NCH-1:0] ch_mask;
    logic [1:0]     res_sel;
    logic           en_resl;
    logic           en_resh;
    logic [NCH-1:0] ch_en;
    logic           busy;
    logic           ready;
    logic           aborted;

    analog_power_sequencer #(
        .NUM_CH      (NCH),
        .BIAS_SETTLE (BS),
        .CH_SETTLE   (CS)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .req_on  (req_on),
        .ch_mask (ch_mask),
        .res_sel (res_sel),
        .en_resl (en_resl),
        .en_resh (en_resh),
        .ch_en   (ch_en),
        .busy    (busy),
        .ready   (ready),
        .aborted (aborted)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Event schedule of the current run, as absolute edge numbers.
    int         m_A, m_Tr, m_S, m_Tb, m_Ti;
    logic [1:0] m_res;
    int         m_on [NCH];
    int         m_off[NCH];

    int meas_on[NCH];
    int meas_ready, meas_idle;

    typedef struct packed {
        logic [3:0] mask;
        logic [1:0] res;
        int         drop_rel;
        int         on0, on1, on2, on3;
        int         rdy;
        int         idle;
    } vec_t;

    vec_t tbl[4];

    function automatic logic [8:0] outs();
        return {en_resl, en_resh, ch_en, busy, ready, aborted};
    endfunction

    task automatic chk(input string name, input logic [8:0] got, input logic [8:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s edge %0d: got {resl,resh,ch,busy,rdy,abt}=%b expected %b", name, cyc, got, exp);
        end
    endtask

    task automatic chk_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic wait_to(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Request first sampled at edge a, drop first sampled at edge d.
    task automatic plan(input logic [3:0] mask, input logic [1:0] res, input int a, input int d);
        int t1, n, s, m;
        m_A   = a;
        m_res = res;
        t1    = a + 1 + BS;
        n     = 0;
        for (int i = 0; i < NCH; i++) begin
            m_on[i]  = INF;
            m_off[i] = INF;
            if (mask[i]) begin
                m_on[i] = t1 + n * CS;
                n++;
            end
        end
        m_Tr = t1 + n * CS;
        if (d < m_Tr) begin
            s = t1;
            while (s <= d) s += CS;
        end else begin
            s = d + 1;
        end
        m = 0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (m_on[i] >= s) m_on[i] = INF;
            if (m_on[i] != INF) begin
                m_off[i] = s + m * CS;
                m++;
            end
        end
        m_S  = s;
        m_Tb = s + m * CS;
        m_Ti = m_Tb + BS;
    endtask

    function automatic logic [8:0] model_at(input int t);
        logic [3:0] ch;
        logic       act, rl, rh, rd, bz;
        act = (t >= m_A + 1);
        rl  = m_res[0] && act && (t < m_Tb);
        rh  = m_res[1] && act && (t < m_Tb);
        for (int i = 0; i < NCH; i++) ch[i] = (t >= m_on[i]) && (t < m_off[i]);
        rd  = (m_Tr < m_S) && (t >= m_Tr) && (t < m_S);
        bz  = act && (t < m_Ti) && !rd;
        return {rl, rh, ch, bz, rd, 1'b0};
    endfunction

    task automatic run_scn(input logic [3:0] mask, input logic [1:0] res, input int drop_rel);
        int   a, d;
        logic prev_busy;
        @(negedge clk);
        a       = cyc + 1;
        d       = a + drop_rel;
        req_on  = 1'b1;
        ch_mask = mask;
        res_sel = res;
        plan(mask, res, a, d);
        for (int i = 0; i < NCH; i++) meas_on[i] = -1;
        meas_ready = -1;
        meas_idle  = -1;
        prev_busy  = 1'b0;
        while (cyc < m_Ti + 2) begin
            @(negedge clk);
            chk("seq", outs(), model_at(cyc));
            for (int i = 0; i < NCH; i++)
                if (ch_en[i] && meas_on[i] < 0) meas_on[i] = cyc - a;
            if (ready && meas_ready < 0) meas_ready = cyc - a;
            if (prev_busy && !busy) meas_idle = cyc - a;
            prev_busy = busy;
            if (cyc + 1 == d) req_on = 1'b0;
            // Latched configuration must ignore later changes.
            if (cyc >= a) begin
                ch_mask = 4'($urandom);
                res_sel = 2'($urandom);
            end
        end
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a, d;
        int eon[NCH];

        tbl[0] = '{4'b1011, 2'b01, 123, 65, 81, -1, 97, 113, 236};
        tbl[1] = '{4'b0000, 2'b11,  75, -1, -1, -1, -1,  65, 140};
        tbl[2] = '{4'b1011, 2'b01,  70, 65, -1, -1, -1,  -1, 161};
        tbl[3] = '{4'b1111, 2'b10, 100, 65, 81, 97, -1,  -1, 225};

        rst_n   = 1'b0;
        ena     = 1'b1;
        req_on  = 1'b0;
        ch_mask = '0;
        res_sel = 2'b00;
        repeat (3) begin
            @(negedge clk);
            chk("reset_hold", outs(), 9'b0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_release", outs(), 9'b0);

        for (int r = 0; r < 4; r++) begin
            run_scn(tbl[r].mask, tbl[r].res, tbl[r].drop_rel);
            eon = '{tbl[r].on0, tbl[r].on1, tbl[r].on2, tbl[r].on3};
            for (int i = 0; i < NCH; i++) chk_int($sformatf("tbl%0d_ch%0d_on", r, i), meas_on[i], eon[i]);
            chk_int($sformatf("tbl%0d_ready", r), meas_ready, tbl[r].rdy);
            chk_int($sformatf("tbl%0d_idle", r), meas_idle, tbl[r].idle);
        end

        // ena low while channels are rising
        @(negedge clk);
        a = cyc + 1; req_on = 1'b1; ch_mask = 4'b1111; res_sel = 2'b01;
        wait_to(a + 70);
        chk("abort_pre", outs(), 9'b1_0_0001_1_0_0);
        ena = 1'b0;
        @(negedge clk);
        chk("abort_edge", outs(), 9'b0_0_0000_0_0_1);
        req_on = 1'b0;
        @(negedge clk);
        chk("abort_pulse_end", outs(), 9'b0);
        ena = 1'b1;
        @(negedge clk);
        ena = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("ena_low_in_off", outs(), 9'b0);
        end
        ena = 1'b1;

        // res_sel == 0 is never accepted
        @(negedge clk);
        req_on = 1'b1; res_sel = 2'b00; ch_mask = 4'b1111;
        repeat (80) begin
            @(negedge clk);
            chk("res_zero_stays_off", outs(), 9'b0);
        end
        req_on = 1'b0;
        repeat (2) @(negedge clk);

        // req_on re-raised during power-down is ignored until OFF, then re-accepted
        @(negedge clk);
        a = cyc + 1; req_on = 1'b1; ch_mask = 4'b0001; res_sel = 2'b01;
        d = a + 90;
        wait_to(d - 1); req_on = 1'b0;
        wait_to(d);      chk("redo_on_hold", outs(), 9'b1_0_0001_0_1_0);
        wait_to(d + 1);  chk("redo_ch_off", outs(), 9'b1_0_0000_1_0_0);
        wait_to(d + 2);  req_on = 1'b1;
        wait_to(d + 16); chk("redo_bias_hold", outs(), 9'b1_0_0000_1_0_0);
        wait_to(d + 17); chk("redo_bias_off", outs(), 9'b0_0_0000_1_0_0);
        wait_to(d + 80); chk("redo_settle", outs(), 9'b0_0_0000_1_0_0);
        wait_to(d + 81); chk("redo_off", outs(), 9'b0);
        wait_to(d + 82); chk("redo_reaccept", outs(), 9'b1_0_0000_1_0_0);
        ena = 1'b0; req_on = 1'b0;
        @(negedge clk);
        chk("redo_abort", outs(), 9'b0_0_0000_0_0_1);
        ena = 1'b1;
        repeat (2) @(negedge clk);

        // asynchronous reset in the middle of power-down
        @(negedge clk);
        a = cyc + 1; req_on = 1'b1; ch_mask = 4'b1111; res_sel = 2'b11;
        wait_to(a + 135); req_on = 1'b0;
        d = a + 136;
        wait_to(d + 20);
        chk("down_pre_reset", outs(), 9'b1_1_0011_1_0_0);
        #3 rst_n = 1'b0;
        #1 chk("async_reset", outs(), 9'b0);
        @(negedge clk);
        chk("async_reset_hold", outs(), 9'b0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("after_reset", outs(), 9'b0);

        for (int k = 0; k < 12; k++) begin
            run_scn(4'($urandom_range(0, 15)), 2'($urandom_range(1, 3)), int'($urandom_range(1, 200)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
